mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-read/write port of the unified instruction/data MemArray between
//  the fetch unit (I-port) and the load/store stage (D-port). Per-cycle arbitration with
//  data priority, a starvation guard for fetch, and 1-cycle read-data return with
//  VALID tagging. Out-of-range data addresses never reach memory. Sits between the
//  pipeline and MemArray; the IO decode (keys/switches/LEDs) is handled outside.
// PARAMETERS
//  DBITS    16  data/address width
//  ABITS    12  memory word-address width (byte address bits [ABITS:1])
//  MAXWAIT  3   max consecutive D grants while IREQ is pending before fetch is forced
// PORTS
//  CLK      in   1       clock, all state on posedge
//  RESET_N  in   1       asynchronous, active-low reset
//  IREQ     in   1       fetch request; IADDR held stable until IGNT
//  IADDR    in   DBITS   fetch byte address
//  IGNT     out  1       fetch granted this cycle (combinational)
//  IVALID   out  1       IDATA valid (registered, 1 cycle after IGNT)
//  IDATA    out  DBITS   fetched word
//  DREQ     in   1       data request; DWE/DADDR/DWDATA held stable until DGNT
//  DWE      in   1       1 = store, 0 = load
//  DADDR    in   DBITS   data byte address
//  DWDATA   in   DBITS   store data
//  DGNT     out  1       data granted this cycle (combinational; completes a store)
//  DVALID   out  1       DRDATA valid (registered, 1 cycle after a load's DGNT)
//  DRDATA   out  DBITS   load data
//  MADDR    out  ABITS   memory word address
//  MWE      out  1       memory write enable
//  MDIN     out  DBITS   memory write data
//  MDOUT    in   DBITS   memory read data (synchronous, valid 1 cycle after MADDR)
// BEHAVIOUR
//  - Reset: IVALID=DVALID=0, return tag=NONE, wait counter=0, oor flag=0. MWE=0, IGNT=DGNT=0
//    while RESET_N=0. A load/fetch in flight at reset is dropped; no VALID follows.
//  - Grant: force = IREQ && (wcnt==MAXWAIT). DGNT = DREQ && !force; IGNT = IREQ && !DGNT.
//    At most one grant per cycle.
//  - Wait counter (2-bit min, sized for MAXWAIT): +1 on cycles with DGNT && IREQ;
//    cleared on IGNT or when IREQ=0; saturates at MAXWAIT.
//  - Memory drive: MADDR = DGNT ? DADDR[ABITS:1] : IADDR[ABITS:1]; bit 0 ignored.
//    MDIN = DWDATA. in_range = (DADDR[DBITS-1:ABITS+1]==0).
//    MWE = DGNT && DWE && in_range.
//  - Return tag FSM (registered), states NONE/IRET/DRET, next state each cycle:
//    IGNT -> IRET; DGNT && !DWE -> DRET (oor flag <= !in_range); else -> NONE.
//    IVALID = (tag==IRET); DVALID = (tag==DRET). Back-to-back grants pipeline fully,
//    one access per cycle, no bubble.
//  - IDATA = MDOUT. DRDATA = oor ? 16'hDEAD (zero-extended/truncated to DBITS) : MDOUT.
//  - Stores produce no DVALID. A load right after a store to the same word returns
//    the new data (memory write-then-read ordering).
//  - Idle cycle (no REQ): tag -> NONE, MWE=0, MADDR follows IADDR.
// TESTING
//  1 Hold RESET_N=0 with IREQ=DREQ=1 -> IGNT=DGNT=MWE=IVALID=DVALID=0; release -> DGNT=1.
//  2 IREQ only, IADDR=0x0200, mem[0x100]=0x1234 -> IGNT same cycle, MADDR=0x100,
//    next cycle IVALID=1, IDATA=0x1234.
//  3 DREQ+IREQ held continuously, all loads, MAXWAIT=3 -> grant sequence D,D,D,I,D,D,D,I;
//    each D followed by DVALID=1, each I by IVALID=1.
//  4 Store DADDR=0x0010, DWDATA=0xBEEF, then load 0x0010 -> MWE=1 once, next DRDATA=0xBEEF.
//  5 Store to 0xFFF0 -> DGNT=1, MWE=0; load 0xFFF2 -> DVALID=1, DRDATA=0xDEAD.
//  6 Load granted, RESET_N pulsed low before next edge -> no DVALID, counter 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory bus of the shared MemArray port: fetch (i*), load/store (d*) and memory (m*).
// Handshake: a request is raised with its address/data and held unchanged until the matching
// grant is seen high in the same cycle; read data returns one cycle later tagged by *valid.
interface mem_port_arbiter_if #(
    parameter int DBITS = 16,
    parameter int ABITS = 12
);
    logic             ireq;
    logic [DBITS-1:0] iaddr;
    logic             ignt;
    logic             ivalid;
    logic [DBITS-1:0] idata;
    logic             dreq;
    logic             dwe;
    logic [DBITS-1:0] daddr;
    logic [DBITS-1:0] dwdata;
    logic             dgnt;
    logic             dvalid;
    logic [DBITS-1:0] drdata;
    logic [ABITS-1:0] maddr;
    logic             mwe;
    logic [DBITS-1:0] mdin;
    logic [DBITS-1:0] mdout;

    modport slave (
        input  ireq, iaddr, dreq, dwe, daddr, dwdata, mdout,
        output ignt, ivalid, idata, dgnt, dvalid, drdata, maddr, mwe, mdin
    );

    modport master (
        output ireq, iaddr, dreq, dwe, daddr, dwdata, mdout,
        input  ignt, ivalid, idata, dgnt, dvalid, drdata, maddr, mwe, mdin
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single MemArray port between fetch and load/store: data priority with a
// fetch starvation guard, 1-cycle tagged read return, out-of-range stores suppressed.
module mem_port_arbiter #(
    parameter int DBITS   = 16,
    parameter int ABITS   = 12,
    parameter int MAXWAIT = 3,
    localparam int WW = ($clog2(MAXWAIT + 1) > 2) ? $clog2(MAXWAIT + 1) : 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]    dbg_tag,
    output logic [WW-1:0] dbg_wcnt
);
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IRET = 2'd1,
        TAG_DRET = 2'd2
    } tag_t;

    localparam logic [DBITS-1:0] DEAD = DBITS'(16'hDEAD);

    tag_t          tag, tag_next;
    logic [WW-1:0] wcnt;
    logic          oor;
    logic          force_fetch;
    logic          dgnt;
    logic          ignt;
    logic          in_range;

    generate
        if (ABITS + 1 < DBITS) begin : g_range
            assign in_range = (bus.daddr[DBITS-1:ABITS+1] == '0);
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    // Grants are held off while in reset so nothing reaches memory.
    assign force_fetch = bus.ireq && (wcnt == WW'(MAXWAIT));
    assign dgnt        = rst_n && bus.dreq && !force_fetch;
    assign ignt        = rst_n && bus.ireq && !dgnt;

    assign bus.dgnt  = dgnt;
    assign bus.ignt  = ignt;
    assign bus.maddr = dgnt ? bus.daddr[ABITS:1] : bus.iaddr[ABITS:1];
    assign bus.mdin  = bus.dwdata;
    assign bus.mwe   = dgnt && bus.dwe && in_range;

    // Counts data grants that overtook a pending fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (!bus.ireq || ignt) begin
            wcnt <= '0;
        end else if (dgnt && (wcnt != WW'(MAXWAIT))) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= TAG_NONE;
            oor <= 1'b0;
        end else begin
            tag <= tag_next;
            if (dgnt && !bus.dwe) begin
                oor <= !in_range;
            end
        end
    end

    always_comb begin
        tag_next = TAG_NONE;
        if (ignt) begin
            tag_next = TAG_IRET;
        end else if (dgnt && !bus.dwe) begin
            tag_next = TAG_DRET;
        end
    end

    always_comb begin
        bus.ivalid = (tag == TAG_IRET);
        bus.dvalid = (tag == TAG_DRET);
        bus.idata  = bus.mdout;
        bus.drdata = oor ? DEAD : bus.mdout;
    end

    assign dbg_tag  = tag;
    assign dbg_wcnt = wcnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run scored against a transaction-level reference of the shared port.
module tb_mem_port_arbiter;
    localparam int DBITS   = 16;
    localparam int ABITS   = 12;
    localparam int MAXWAIT = 3;
    localparam int NRAND   = 600;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_tag;
    logic [1:0] dbg_wcnt;

    mem_port_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

    mem_port_arbiter #(.DBITS(DBITS), .ABITS(ABITS), .MAXWAIT(MAXWAIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_tag  (dbg_tag),
        .dbg_wcnt (dbg_wcnt)
    );

    // clock / memory array
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];

    always @(posedge clk) begin
        if (bus.mwe) mem[bus.maddr] <= bus.mdin;
        bus.mdout <= mem[bus.maddr];
    end

    // scoreboard
    int n_pass  = 0;
    int n_total = 0;
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic ireq, input logic [15:0] iaddr, input logic dreq,
                         input logic dwe, input logic [15:0] daddr, input logic [15:0] dwdata);
        bus.ireq   = ireq;
        bus.iaddr  = iaddr;
        bus.dreq   = dreq;
        bus.dwe    = dwe;
        bus.daddr  = daddr;
        bus.dwdata = dwdata;
    endtask

    typedef struct {
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        e_ignt;
        logic        e_dgnt;
        logic        e_mwe;
        logic [11:0] e_maddr;
        logic        e_ivalid;
        logic        e_dvalid;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        i_pend, d_pend, r_dwe, e_i, e_d, e_mwe, inr;
        logic [15:0] r_iaddr, r_daddr, r_dwdata;
        logic [17:0] front;
        int          waited;
        logic        prev_i, prev_d;

        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h000] = 16'h0A0A;
        mem[12'h100] = 16'h1234;
        mem[12'h010] = 16'h2222;
        mem[12'hFF8] = 16'h5555;

        vecs[0]  = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 16'h1234};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b1, 12'h008, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h008, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 16'hBEEF};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF0, 16'h1111, 1'b0, 1'b1, 1'b0, 12'hFF8, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFF2, 16'h0000, 1'b0, 1'b1, 1'b0, 12'hFF9, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 16'hDEAD};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1FF0, 16'h0000, 1'b0, 1'b1, 1'b0, 12'hFF8, 1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h5555};
        vecs[10] = '{1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 16'h0200, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 12'h008, 1'b1, 1'b0, 16'h1234};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 16'hBEEF};

        // reset held with both requests up: nothing granted, nothing valid
        rst_n = 1'b0;
        drive(1'b1, 16'h0200, 1'b1, 1'b1, 16'h0040, 16'h7777);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ignt",   32'(bus.ignt),   32'd0);
        check("rst_dgnt",   32'(bus.dgnt),   32'd0);
        check("rst_mwe",    32'(bus.mwe),    32'd0);
        check("rst_ivalid", 32'(bus.ivalid), 32'd0);
        check("rst_dvalid", 32'(bus.dvalid), 32'd0);
        check("rst_tag",    32'(dbg_tag),    32'd0);
        check("rst_wcnt",   32'(dbg_wcnt),   32'd0);

        @(negedge clk);
        drive(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("rel_dgnt", 32'(bus.dgnt), 32'd1);
        check("rel_ignt", 32'(bus.ignt), 32'd0);
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("rel_dvalid", 32'(bus.dvalid), 32'd1);
        check("rel_drdata", 32'(bus.drdata), 32'h0A0A);
        check("rel_wcnt",   32'(dbg_wcnt),   32'd1);

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
            #1;
            check($sformatf("v%0d_ignt", i),   32'(bus.ignt),   32'(vecs[i].e_ignt));
            check($sformatf("v%0d_dgnt", i),   32'(bus.dgnt),   32'(vecs[i].e_dgnt));
            check($sformatf("v%0d_mwe", i),    32'(bus.mwe),    32'(vecs[i].e_mwe));
            check($sformatf("v%0d_maddr", i),  32'(bus.maddr),  32'(vecs[i].e_maddr));
            check($sformatf("v%0d_ivalid", i), 32'(bus.ivalid), 32'(vecs[i].e_ivalid));
            check($sformatf("v%0d_dvalid", i), 32'(bus.dvalid), 32'(vecs[i].e_dvalid));
            if (vecs[i].e_ivalid) check($sformatf("v%0d_idata", i), 32'(bus.idata), 32'(vecs[i].e_data));
            if (vecs[i].e_dvalid) check($sformatf("v%0d_drdata", i), 32'(bus.drdata), 32'(vecs[i].e_data));
        end

        // both ports requesting continuously: D,D,D,I repeating
        prev_i = 1'b0;
        prev_d = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0020, 16'h0000);
            #1;
            e_i = ((k % 4) == 3);
            check($sformatf("starve%0d_ignt", k),   32'(bus.ignt),   32'(e_i));
            check($sformatf("starve%0d_dgnt", k),   32'(bus.dgnt),   32'(!e_i));
            check($sformatf("starve%0d_ivalid", k), 32'(bus.ivalid), 32'(prev_i));
            check($sformatf("starve%0d_dvalid", k), 32'(bus.dvalid), 32'(prev_d));
            if (prev_i) check($sformatf("starve%0d_idata", k), 32'(bus.idata), 32'h1234);
            if (prev_d) check($sformatf("starve%0d_drdata", k), 32'(bus.drdata), 32'h2222);
            prev_i = e_i;
            prev_d = !e_i;
        end
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        check("starve_end_dvalid", 32'(bus.dvalid), 32'(prev_d));

        // load granted, reset pulsed before the return edge: the return is dropped
        @(negedge clk);
        drive(1'b1, 16'h0200, 1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        check("abort_dgnt", 32'(bus.dgnt), 32'd1);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        #1;
        check("abort_dvalid", 32'(bus.dvalid), 32'd0);
        check("abort_ivalid", 32'(bus.ivalid), 32'd0);
        check("abort_wcnt",   32'(dbg_wcnt),   32'd0);
        check("abort_tag",    32'(dbg_tag),    32'd0);

        // randomized traffic against a transaction-level reference
        @(negedge clk);
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        i_pend = 1'b0;
        d_pend = 1'b0;
        r_iaddr = '0; r_daddr = '0; r_dwdata = '0; r_dwe = 1'b0;
        waited = 0;
        exp_q.push_back(18'd0);
        for (int c = 0; c <= NRAND; c++) begin
            @(negedge clk);
            if (c < NRAND && !i_pend && $urandom_range(0, 99) < 60) begin
                i_pend  = 1'b1;
                r_iaddr = 16'($urandom_range(0, 127));
                waited  = 0;
            end
            if (c < NRAND && !d_pend && $urandom_range(0, 99) < 70) begin
                d_pend   = 1'b1;
                r_dwe    = 1'($urandom_range(0, 1));
                r_daddr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
                r_dwdata = 16'($urandom);
            end
            drive(i_pend, r_iaddr, d_pend, r_dwe, r_daddr, r_dwdata);
            #1;
            // a fetch that has already let MAXWAIT data accesses through must go next
            e_d   = d_pend && !(i_pend && waited >= MAXWAIT);
            e_i   = i_pend && !e_d;
            inr   = (r_daddr[15:13] == 3'd0);
            e_mwe = e_d && r_dwe && inr;
            check("rnd_ignt",  32'(bus.ignt),  32'(e_i));
            check("rnd_dgnt",  32'(bus.dgnt),  32'(e_d));
            check("rnd_mwe",   32'(bus.mwe),   32'(e_mwe));
            check("rnd_maddr", 32'(bus.maddr), e_d ? 32'(r_daddr[12:1]) : 32'(r_iaddr[12:1]));
            if (exp_q.size() == 0) begin
                check("rnd_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                front = exp_q.pop_front();
                check("rnd_ivalid", 32'(bus.ivalid), 32'(front[17:16] == 2'd1));
                check("rnd_dvalid", 32'(bus.dvalid), 32'(front[17:16] == 2'd2));
                if (front[17:16] == 2'd1) check("rnd_idata", 32'(bus.idata), 32'(front[15:0]));
                if (front[17:16] == 2'd2) check("rnd_drdata", 32'(bus.drdata), 32'(front[15:0]));
            end
            if (e_i)                exp_q.push_back({2'd1, ref_mem[r_iaddr[12:1]]});
            else if (e_d && !r_dwe) exp_q.push_back({2'd2, inr ? ref_mem[r_daddr[12:1]] : 16'hDEAD});
            else                    exp_q.push_back(18'd0);
            if (e_mwe) ref_mem[r_daddr[12:1]] = r_dwdata;
            if (e_i) i_pend = 1'b0;
            else if (e_d && i_pend) waited++;
            if (e_d) d_pend = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
